game_level_sequencer: RTL and testbench
=======================================

// Module: game_level_sequencer
// PURPOSE
// Top-level game flow controller, directly downstream of the per-level blocks: consumes the active level's win/lose flags.
// Selects which level is live, drives that level's active-low reset, tracks lives, and sequences title/clear/lose/game-over screens.
// Outputs feed the level mux and the VGA screen selector.
// PARAMETERS
// NUM_LEVELS         2           number of levels; level_select counts 0..NUM_LEVELS-1
// START_LIVES        3           lives loaded at game start (1..15)
// HOLD_CYCLES        50_000_000  vga_clock cycles a clear/lose banner is held (2 s @ 25 MHz)
// RESET_PULSE_CYCLES 4           cycles level_reset_n is held low on each level load
// PORTS
// vga_clock      in   1                     system clock
// reset          in   1                     synchronous, active-high
// start_button   in   1                     level signal, synchronous to vga_clock
// level_win      in   1                     win from the currently selected level
// level_lose     in   1                     lose from the currently selected level
// level_select   out  $clog2(NUM_LEVELS)    index of the live level
// level_reset_n  out  1                     active-low reset to the selected level
// play_active    out  1                     1 only in PLAY
// screen_id      out  3                     game_pkg::screen_t encoding of the current screen
// lives          out  4                     remaining lives
// BEHAVIOUR
// - One clock; reset is synchronous and active-high. On reset: state=TITLE, level_select=0, lives=START_LIVES,
//   level_reset_n=0, play_active=0, screen_id=SCR_TITLE, hold counter=0, start edge register=0.
// - start edge: start_q registered each cycle; start_rise = start_button & ~start_q. Only rises act; holding does nothing.
// - States: TITLE, LOAD, PLAY, CLEAR, LOSE, GAME_OVER, GAME_WON. All outputs are registered (Moore).
// - TITLE: level_reset_n=0. start_rise -> level_select=0, lives=START_LIVES, go LOAD.
// - LOAD: level_reset_n=0 for exactly RESET_PULSE_CYCLES cycles (counter from 0), then PLAY with level_reset_n=1.
// - PLAY: level_reset_n=1, play_active=1. First PLAY cycle ignores win/lose (settle guard).
//   Afterwards: level_win -> CLEAR; else level_lose -> LOSE. Win has priority when both high in the same cycle.
// - CLEAR: level_reset_n stays 1 (level frozen as-is, banner shown). After HOLD_CYCLES cycles:
//   level_select==NUM_LEVELS-1 -> GAME_WON; else level_select+1, go LOAD.
// - LOSE: lives decremented by 1 on entry (saturates at 0). After HOLD_CYCLES cycles: lives==0 -> GAME_OVER; else LOAD same level.
// - GAME_OVER / GAME_WON: level_reset_n=0; start_rise -> TITLE. Never self-exit.
// - Hold counter: cleared on every state entry; width $clog2(HOLD_CYCLES+1); no wrap (exit at terminal count).
// - start_rise is ignored in LOAD, PLAY, CLEAR, LOSE.
// - Reset mid-operation (any state, any counter value): next cycle matches the reset values exactly; level_reset_n drops to 0 the same edge.
// - screen_id: TITLE=0, PLAY=1 (also during LOAD), CLEAR=2, LOSE=3, GAME_OVER=4, GAME_WON=5.
// STRUCTURE
// - game_pkg: typedef enum logic [2:0] screen_t {SCR_TITLE, SCR_PLAY, SCR_CLEAR, SCR_LOSE, SCR_OVER, SCR_WON};
//   sequencer state enum; default START_LIVES/HOLD_CYCLES constants shared with the VGA screen selector.
// - One sub-module: hold_timer (start, terminal count parameter, done pulse), reused for LOAD pulse and banner hold.
// - Edge detect and FSM inline.
// TESTING (bench params: NUM_LEVELS=2, START_LIVES=2, HOLD_CYCLES=8, RESET_PULSE_CYCLES=4)
// - Reset high 2 cycles -> TITLE, level_reset_n=0, lives=2, screen_id=0; start held high 20 cycles -> exactly one LOAD entry.
// - start_rise -> level_reset_n low exactly 4 cycles, then PLAY, play_active=1, level_select=0.
// - Win on level 0 -> CLEAR 8 cycles, LOAD, PLAY on level 1; win on level 1 -> GAME_WON, screen_id=5, stays until start_rise -> TITLE.
// - Lose twice -> lives 2->1 (reload level 0), 1->0 -> GAME_OVER, screen_id=4; lives never underflows.
// - win and lose high same cycle in PLAY -> CLEAR; win/lose high on first PLAY cycle only -> ignored, stays PLAY.
// - Assert reset during CLEAR with hold counter=5 -> next cycle all reset values, level_select=0.

Source files
------------

// File: rtl/game_level_sequencer_pkg.sv
// game_level_sequencer_pkg
// Shared types and defaults for the game flow controller.
//   screen_t     : screen encoding consumed by the VGA screen selector
//   seq_state_t  : sequencer FSM states (also exported for debug)
//   DEFAULT_*    : default parameter values shared with the screen selector
//   screen_of()  : maps a sequencer state to the screen it displays
package game_level_sequencer_pkg;

    typedef enum logic [2:0] {
        SCR_TITLE = 3'd0,
        SCR_PLAY  = 3'd1,
        SCR_CLEAR = 3'd2,
        SCR_LOSE  = 3'd3,
        SCR_OVER  = 3'd4,
        SCR_WON   = 3'd5
    } screen_t;

    typedef enum logic [2:0] {
        ST_TITLE     = 3'd0,
        ST_LOAD      = 3'd1,
        ST_PLAY      = 3'd2,
        ST_CLEAR     = 3'd3,
        ST_LOSE      = 3'd4,
        ST_GAME_OVER = 3'd5,
        ST_GAME_WON  = 3'd6
    } seq_state_t;

    localparam int DEFAULT_NUM_LEVELS         = 2;
    localparam int DEFAULT_START_LIVES        = 3;
    localparam int DEFAULT_HOLD_CYCLES        = 50_000_000;
    localparam int DEFAULT_RESET_PULSE_CYCLES = 4;

    // LOAD shows the play screen: the level is being reset underneath it.
    function automatic screen_t screen_of(input seq_state_t s);
        case (s)
            ST_TITLE:     return SCR_TITLE;
            ST_LOAD:      return SCR_PLAY;
            ST_PLAY:      return SCR_PLAY;
            ST_CLEAR:     return SCR_CLEAR;
            ST_LOSE:      return SCR_LOSE;
            ST_GAME_OVER: return SCR_OVER;
            ST_GAME_WON:  return SCR_WON;
            default:      return SCR_TITLE;
        endcase
    endfunction

endpackage

// File: rtl/game_level_sequencer_if.sv
// game_level_sequencer_if
// Signal bundle between the sequencer and the level mux / screen selector.
//   start_button, level_win, level_lose : into the sequencer
//   level_select, level_reset_n, play_active, screen_id, lives : out of it
//   dbg_state : current sequencer state, for observation only
// All signals are plain levels synchronous to vga_clock; there is no
// valid/ready handshake. Inputs are sampled on every rising edge, outputs
// change only on rising edges.
// Modports: master = sequencer side, slave = environment side.
interface game_level_sequencer_if #(
    parameter int NUM_LEVELS = game_level_sequencer_pkg::DEFAULT_NUM_LEVELS
);
    localparam int LVL_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;

    logic                                  start_button;
    logic                                  level_win;
    logic                                  level_lose;
    logic [LVL_W-1:0]                      level_select;
    logic                                  level_reset_n;
    logic                                  play_active;
    game_level_sequencer_pkg::screen_t     screen_id;
    logic [3:0]                            lives;
    game_level_sequencer_pkg::seq_state_t  dbg_state;

    modport master (
        input  start_button, level_win, level_lose,
        output level_select, level_reset_n, play_active, screen_id, lives, dbg_state
    );

    modport slave (
        output start_button, level_win, level_lose,
        input  level_select, level_reset_n, play_active, screen_id, lives, dbg_state
    );
endinterface

// File: rtl/game_level_sequencer_hold_timer.sv
// game_level_sequencer_hold_timer
// Counts cycles since the last start pulse; done is high for the single
// cycle in which the count reaches TC-1, so a state that restarts the timer
// on entry and leaves on done lasts exactly TC cycles.
//   clk, reset : clock, synchronous active-high reset
//   start      : clears the count (next cycle reads 0)
//   done       : one-cycle pulse at count TC-1
// The count saturates at TC and never wraps. TC must be >= 1.
module game_level_sequencer_hold_timer #(
    parameter int TC = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic done
);
    localparam int W = $clog2(TC + 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || start) begin
            cnt_q <= '0;
        end else if (cnt_q != W'(TC)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign done = (cnt_q == W'(TC - 1));
endmodule

// File: rtl/game_level_sequencer.sv
// game_level_sequencer
// Top-level game flow: picks the live level, pulses its active-low reset on
// every load, tracks lives and sequences the title / clear / lose /
// game-over / game-won screens.
//   vga_clock : system clock
//   reset     : synchronous, active-high
//   game_if   : game_level_sequencer_if.master (see interface header)
// All outputs are registered from the next state (Moore).
module game_level_sequencer
    import game_level_sequencer_pkg::*;
#(
    parameter int NUM_LEVELS         = DEFAULT_NUM_LEVELS,
    parameter int START_LIVES        = DEFAULT_START_LIVES,
    parameter int HOLD_CYCLES        = DEFAULT_HOLD_CYCLES,
    parameter int RESET_PULSE_CYCLES = DEFAULT_RESET_PULSE_CYCLES
) (
    input  logic                  vga_clock,
    input  logic                  reset,
    game_level_sequencer_if.master game_if
);
    localparam int LVL_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;

    seq_state_t       state_q, state_n;
    logic             start_q, start_rise;
    logic             settle_q;
    logic [3:0]       lives_q, lives_n;
    logic [LVL_W-1:0] level_q, level_n;
    logic             state_change, load_done, hold_done;
    logic             level_reset_n_q, play_active_q;
    screen_t          screen_q;

    assign start_rise   = game_if.start_button & ~start_q;
    // Every state entry restarts both timers, so each state counts from 0.
    assign state_change = (state_n != state_q);

    game_level_sequencer_hold_timer #(.TC(RESET_PULSE_CYCLES)) u_load_timer (
        .clk   (vga_clock),
        .reset (reset),
        .start (state_change),
        .done  (load_done)
    );

    game_level_sequencer_hold_timer #(.TC(HOLD_CYCLES)) u_hold_timer (
        .clk   (vga_clock),
        .reset (reset),
        .start (state_change),
        .done  (hold_done)
    );

    always_comb begin
        state_n = state_q;
        lives_n = lives_q;
        level_n = level_q;
        case (state_q)
            ST_TITLE: begin
                if (start_rise) begin
                    state_n = ST_LOAD;
                    level_n = '0;
                    lives_n = 4'(START_LIVES);
                end
            end
            ST_LOAD: begin
                if (load_done) state_n = ST_PLAY;
            end
            ST_PLAY: begin
                // settle_q is low on the first PLAY cycle, while the freshly
                // released level may still present stale win/lose flags.
                if (settle_q) begin
                    if (game_if.level_win) begin
                        state_n = ST_CLEAR;
                    end else if (game_if.level_lose) begin
                        state_n = ST_LOSE;
                        lives_n = (lives_q == 4'd0) ? 4'd0 : lives_q - 4'd1;
                    end
                end
            end
            ST_CLEAR: begin
                if (hold_done) begin
                    if (level_q == LVL_W'(NUM_LEVELS - 1)) begin
                        state_n = ST_GAME_WON;
                    end else begin
                        level_n = level_q + LVL_W'(1);
                        state_n = ST_LOAD;
                    end
                end
            end
            ST_LOSE: begin
                if (hold_done) state_n = (lives_q == 4'd0) ? ST_GAME_OVER : ST_LOAD;
            end
            ST_GAME_OVER, ST_GAME_WON: begin
                if (start_rise) state_n = ST_TITLE;
            end
            default: state_n = ST_TITLE;
        endcase
    end

    always_ff @(posedge vga_clock) begin
        if (reset) begin
            state_q         <= ST_TITLE;
            start_q         <= 1'b0;
            settle_q        <= 1'b0;
            lives_q         <= 4'(START_LIVES);
            level_q         <= '0;
            level_reset_n_q <= 1'b0;
            play_active_q   <= 1'b0;
            screen_q        <= SCR_TITLE;
        end else begin
            state_q         <= state_n;
            start_q         <= game_if.start_button;
            settle_q        <= (state_q == ST_PLAY) && (state_n == ST_PLAY);
            lives_q         <= lives_n;
            level_q         <= level_n;
            // The level keeps running (frozen by its own logic) under the
            // clear/lose banners; it is held in reset everywhere else.
            level_reset_n_q <= (state_n inside {ST_PLAY, ST_CLEAR, ST_LOSE});
            play_active_q   <= (state_n == ST_PLAY);
            screen_q        <= screen_of(state_n);
        end
    end

    assign game_if.level_select  = level_q;
    assign game_if.level_reset_n = level_reset_n_q;
    assign game_if.play_active   = play_active_q;
    assign game_if.screen_id     = screen_q;
    assign game_if.lives         = lives_q;
    assign game_if.dbg_state     = state_q;
endmodule

// File: tb/tb_game_level_sequencer.sv
// tb_game_level_sequencer
// Directed walk through the game flow with NUM_LEVELS=2, START_LIVES=2,
// HOLD_CYCLES=8, RESET_PULSE_CYCLES=4. Expected values are hand-derived.
module tb_game_level_sequencer;
    import game_level_sequencer_pkg::*;

    logic vga_clock;
    logic reset;
    int   checks;
    int   failures;
    int   load_cycles;
    int   low_cycles;

    game_level_sequencer_if #(.NUM_LEVELS(2)) gif ();

    game_level_sequencer #(
        .NUM_LEVELS         (2),
        .START_LIVES        (2),
        .HOLD_CYCLES        (8),
        .RESET_PULSE_CYCLES (4)
    ) dut (
        .vga_clock (vga_clock),
        .reset     (reset),
        .game_if   (gif)
    );

    // clock / reset
    initial vga_clock = 1'b0;
    always #5 vga_clock = ~vga_clock;

    // driver tasks
    task automatic tick();
        @(posedge vga_clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input seq_state_t exp);
        chk(tag, 32'(gif.dbg_state), 32'(exp));
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        gif.start_button = 1'b0;
        gif.level_win = 1'b0;
        gif.level_lose = 1'b0;

        // reset
        ticks(2);
        chk_state("rst_state", ST_TITLE);
        chk("rst_reset_n", 32'(gif.level_reset_n), 32'd0);
        chk("rst_lives", 32'(gif.lives), 32'd2);
        chk("rst_screen", 32'(gif.screen_id), 32'd0);
        chk("rst_play", 32'(gif.play_active), 32'd0);
        chk("rst_level", 32'(gif.level_select), 32'd0);
        reset = 1'b0;

        // start held 20 cycles: one LOAD of exactly 4 cycles, then PLAY
        gif.start_button = 1'b1;
        load_cycles = 0;
        low_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (gif.dbg_state == ST_LOAD) load_cycles++;
            if (!gif.level_reset_n) low_cycles++;
        end
        gif.start_button = 1'b0;
        chk("load_cycles", 32'(load_cycles), 32'd4);
        chk("reset_low_cycles", 32'(low_cycles), 32'd4);
        chk_state("play0_state", ST_PLAY);
        chk("play0_active", 32'(gif.play_active), 32'd1);
        chk("play0_level", 32'(gif.level_select), 32'd0);
        chk("play0_screen", 32'(gif.screen_id), 32'd1);
        chk("play0_reset_n", 32'(gif.level_reset_n), 32'd1);

        // win level 0 -> CLEAR for 8 cycles -> LOAD level 1
        gif.level_win = 1'b1;
        tick();
        gif.level_win = 1'b0;
        chk_state("clear0_state", ST_CLEAR);
        chk("clear0_screen", 32'(gif.screen_id), 32'd2);
        chk("clear0_reset_n", 32'(gif.level_reset_n), 32'd1);
        chk("clear0_play", 32'(gif.play_active), 32'd0);
        ticks(7);
        chk_state("clear0_last", ST_CLEAR);
        tick();
        chk_state("load1_state", ST_LOAD);
        chk("load1_level", 32'(gif.level_select), 32'd1);
        chk("load1_reset_n", 32'(gif.level_reset_n), 32'd0);
        chk("load1_screen", 32'(gif.screen_id), 32'd1);
        ticks(3);
        chk_state("load1_last", ST_LOAD);
        tick();
        chk_state("play1_state", ST_PLAY);
        chk("play1_level", 32'(gif.level_select), 32'd1);

        // win+lose on the first PLAY cycle are ignored
        gif.level_win = 1'b1;
        gif.level_lose = 1'b1;
        tick();
        gif.level_win = 1'b0;
        gif.level_lose = 1'b0;
        chk_state("settle_guard", ST_PLAY);
        chk("settle_lives", 32'(gif.lives), 32'd2);

        // win and lose together: win wins
        gif.level_win = 1'b1;
        gif.level_lose = 1'b1;
        tick();
        gif.level_win = 1'b0;
        gif.level_lose = 1'b0;
        chk_state("win_priority", ST_CLEAR);
        chk("win_priority_lives", 32'(gif.lives), 32'd2);

        // start rise during CLEAR is ignored; last level -> GAME_WON
        gif.start_button = 1'b1;
        tick();
        gif.start_button = 1'b0;
        chk_state("clear_ignores_start", ST_CLEAR);
        ticks(6);
        chk_state("clear1_last", ST_CLEAR);
        tick();
        chk_state("won_state", ST_GAME_WON);
        chk("won_screen", 32'(gif.screen_id), 32'd5);
        chk("won_reset_n", 32'(gif.level_reset_n), 32'd0);
        chk("won_play", 32'(gif.play_active), 32'd0);
        ticks(10);
        chk_state("won_stays", ST_GAME_WON);

        // start rise -> TITLE; holding start does not restart
        gif.start_button = 1'b1;
        tick();
        chk_state("won_to_title", ST_TITLE);
        chk("title_screen", 32'(gif.screen_id), 32'd0);
        tick();
        chk_state("title_hold", ST_TITLE);
        gif.start_button = 1'b0;
        tick();
        gif.start_button = 1'b1;
        tick();
        gif.start_button = 1'b0;
        chk_state("restart_load", ST_LOAD);
        chk("restart_lives", 32'(gif.lives), 32'd2);
        chk("restart_level", 32'(gif.level_select), 32'd0);
        ticks(4);
        chk_state("restart_play", ST_PLAY);
        tick();

        // first loss: lives 2 -> 1, reload level 0
        gif.level_lose = 1'b1;
        tick();
        gif.level_lose = 1'b0;
        chk_state("lose1_state", ST_LOSE);
        chk("lose1_lives", 32'(gif.lives), 32'd1);
        chk("lose1_screen", 32'(gif.screen_id), 32'd3);
        ticks(7);
        chk_state("lose1_last", ST_LOSE);
        tick();
        chk_state("reload_state", ST_LOAD);
        chk("reload_level", 32'(gif.level_select), 32'd0);
        chk("reload_lives", 32'(gif.lives), 32'd1);
        ticks(4);
        chk_state("reload_play", ST_PLAY);
        tick();

        // second loss: lives 1 -> 0 -> GAME_OVER, no underflow
        gif.level_lose = 1'b1;
        tick();
        gif.level_lose = 1'b0;
        chk_state("lose2_state", ST_LOSE);
        chk("lose2_lives", 32'(gif.lives), 32'd0);
        ticks(8);
        chk_state("over_state", ST_GAME_OVER);
        chk("over_screen", 32'(gif.screen_id), 32'd4);
        chk("over_reset_n", 32'(gif.level_reset_n), 32'd0);
        gif.level_lose = 1'b1;
        ticks(5);
        gif.level_lose = 1'b0;
        chk_state("over_stays", ST_GAME_OVER);
        chk("over_lives", 32'(gif.lives), 32'd0);

        // back to TITLE, new game, reach CLEAR on level 1 with lives 1
        gif.start_button = 1'b1;
        tick();
        gif.start_button = 1'b0;
        chk_state("over_to_title", ST_TITLE);
        tick();
        gif.start_button = 1'b1;
        tick();
        gif.start_button = 1'b0;
        chk_state("game3_load", ST_LOAD);
        ticks(4);
        tick();
        gif.level_lose = 1'b1;
        tick();
        gif.level_lose = 1'b0;
        ticks(8);
        ticks(4);
        tick();
        gif.level_win = 1'b1;
        tick();
        gif.level_win = 1'b0;
        ticks(8);
        ticks(4);
        tick();
        gif.level_win = 1'b1;
        tick();
        gif.level_win = 1'b0;
        ticks(5);
        chk_state("pre_reset_state", ST_CLEAR);
        chk("pre_reset_level", 32'(gif.level_select), 32'd1);
        chk("pre_reset_lives", 32'(gif.lives), 32'd1);

        // reset mid-CLEAR (hold count 5)
        reset = 1'b1;
        tick();
        chk_state("midrst_state", ST_TITLE);
        chk("midrst_level", 32'(gif.level_select), 32'd0);
        chk("midrst_lives", 32'(gif.lives), 32'd2);
        chk("midrst_reset_n", 32'(gif.level_reset_n), 32'd0);
        chk("midrst_play", 32'(gif.play_active), 32'd0);
        chk("midrst_screen", 32'(gif.screen_id), 32'd0);
        reset = 1'b0;
        tick();
        chk_state("post_rst_title", ST_TITLE);

        // report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
